// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: two requester handshakes plus the register file write port.
interface regfile_wb_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_num;
    logic [DATA_W-1:0] alu_data;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_num;
    logic [DATA_W-1:0] mem_data;

    logic              writeReg;
    logic [ADDR_W-1:0] write_reg_num;
    logic [DATA_W-1:0] write_data;

    // Requester side: drives requests, observes readies and the write port.
    modport master (
        output alu_valid, alu_num, alu_data,
        output mem_valid, mem_num, mem_data,
        input  alu_ready, mem_ready,
        input  writeReg, write_reg_num, write_data
    );

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_num, alu_data,
        input  mem_valid, mem_num, mem_data,
        output alu_ready, mem_ready,
        output writeReg, write_reg_num, write_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU
// (requester 0) and load (requester 1) writebacks, with a registered
// output stage and a saturating contention counter.
// Optional macro REGFILE_WB_FWD_EN adds read-port forwarding of the write
// being committed this cycle.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned DROP_R0 = 1
) (
    input  logic               clk,
    input  logic               rst,
    regfile_wb_arbiter_if.slave bus,
`ifdef REGFILE_WB_FWD_EN
    input  logic [ADDR_W-1:0]  rd_num_1,
    input  logic [ADDR_W-1:0]  rd_num_2,
    input  logic [DATA_W-1:0]  rd_data_1,
    input  logic [DATA_W-1:0]  rd_data_2,
    output logic [DATA_W-1:0]  fwd_data_1,
    output logic [DATA_W-1:0]  fwd_data_2,
`endif
    output logic [CNT_W-1:0]   conflict_cnt
);

    // 0: ALU granted last, 1: load granted last (ALU wins next contention)
    logic              last_grant;
    logic              grant_alu;
    logic              grant_mem;
    logic              both_valid;
    logic [ADDR_W-1:0] sel_num;
    logic [DATA_W-1:0] sel_data;
    logic              sel_issue;

    // Grant decision: sole requester wins, on contention the one not granted last.
    always_comb begin
        both_valid = bus.alu_valid & bus.mem_valid;
        grant_alu  = 1'b0;
        grant_mem  = 1'b0;
        if (!rst) begin
            grant_alu = bus.alu_valid & (~bus.mem_valid | last_grant);
            grant_mem = bus.mem_valid & (~bus.alu_valid | ~last_grant);
        end
    end

    assign bus.alu_ready = grant_alu;
    assign bus.mem_ready = grant_mem;

    // Winning payload and whether it reaches the register file.
    always_comb begin
        sel_num  = grant_mem ? bus.mem_num  : bus.alu_num;
        sel_data = grant_mem ? bus.mem_data : bus.alu_data;
        sel_issue = 1'b1;
        if ((DROP_R0 != 0) && (sel_num == '0)) begin
            sel_issue = 1'b0;
        end
    end

    // Arbiter history and registered write port; drains every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant        <= 1'b1;
            bus.writeReg      <= 1'b0;
            bus.write_reg_num <= '0;
            bus.write_data    <= '0;
        end else begin
            bus.writeReg <= 1'b0;
            if (grant_alu || grant_mem) begin
                last_grant <= grant_mem;
                if (sel_issue) begin
                    bus.writeReg      <= 1'b1;
                    bus.write_reg_num <= sel_num;
                    bus.write_data    <= sel_data;
                end
            end
        end
    end

    // Saturating count of cycles with both requesters valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (both_valid && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

`ifdef REGFILE_WB_FWD_EN
    // Bypass the write committed this cycle onto the read ports; r0 never forwards.
    always_comb begin
        fwd_data_1 = rd_data_1;
        fwd_data_2 = rd_data_2;
        if (bus.writeReg && (bus.write_reg_num == rd_num_1) && (rd_num_1 != '0)) begin
            fwd_data_1 = bus.write_data;
        end
        if (bus.writeReg && (bus.write_reg_num == rd_num_2) && (rd_num_2 != '0)) begin
            fwd_data_2 = bus.write_data;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a vector table plus hand-written
// contention/saturation and forwarding sequences. dut0 has CNT_W=4 and
// DROP_R0=1; dut1 shares its inputs with CNT_W=16 and DROP_R0=0.
module tb_regfile_wb_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();
    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();

    logic [3:0]  cnt0;
    logic [15:0] cnt1;

    assign bus1.alu_valid = bus0.alu_valid;
    assign bus1.alu_num   = bus0.alu_num;
    assign bus1.alu_data  = bus0.alu_data;
    assign bus1.mem_valid = bus0.mem_valid;
    assign bus1.mem_num   = bus0.mem_num;
    assign bus1.mem_data  = bus0.mem_data;

`ifdef REGFILE_WB_FWD_EN
    logic [4:0]  rd_num_1, rd_num_2;
    logic [31:0] rd_data_1, rd_data_2;
    logic [31:0] fwd0_1, fwd0_2, fwd1_1, fwd1_2;
`endif

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(4), .DROP_R0(1)) dut0 (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus0.slave),
`ifdef REGFILE_WB_FWD_EN
        .rd_num_1     (rd_num_1),
        .rd_num_2     (rd_num_2),
        .rd_data_1    (rd_data_1),
        .rd_data_2    (rd_data_2),
        .fwd_data_1   (fwd0_1),
        .fwd_data_2   (fwd0_2),
`endif
        .conflict_cnt (cnt0)
    );

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(16), .DROP_R0(0)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus1.slave),
`ifdef REGFILE_WB_FWD_EN
        .rd_num_1     (rd_num_1),
        .rd_num_2     (rd_num_2),
        .rd_data_1    (rd_data_1),
        .rd_data_2    (rd_data_2),
        .fwd_data_1   (fwd1_1),
        .fwd_data_2   (fwd1_2),
`endif
        .conflict_cnt (cnt1)
    );

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  an;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mn;
        logic [31:0] md;
        logic        ear;
        logic        emr;
        logic        ewe;
        logic [4:0]  enum_r;
        logic [31:0] edata;
        logic [3:0]  ecnt;
        logic        r0chk;
    } vec_t;

    localparam int unsigned NVEC = 15;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic [4:0] an, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mn, input logic [31:0] md);
        rst            = r;
        bus0.alu_valid = av;
        bus0.alu_num   = an;
        bus0.alu_data  = ad;
        bus0.mem_valid = mv;
        bus0.mem_num   = mn;
        bus0.mem_data  = md;
    endtask

    initial begin
        // rst av an ad mv mn md | ear emr ewe num data cnt r0chk
        vecs[0]  = '{1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        4'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        4'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        4'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 4'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 4'd0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 5'd3, 32'h33,       1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 4'd0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        4'd0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22, 1'b0, 1'b1, 1'b1, 5'd1, 32'h11,       4'd1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 1'b1, 5'd2, 32'h22,       4'd2, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22, 1'b0, 1'b1, 1'b1, 5'd1, 32'h11,       4'd3, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 5'd2, 32'h22,       4'd4, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h55, 1'b0, 1'b1, 1'b0, 5'd2, 32'h22,       4'd4, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd2, 32'h22,       4'd4, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h99, 1'b0, 1'b1, 1'b0, 5'd2, 32'h22,       4'd4, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 5'd9, 32'h99,       4'd4, 1'b0};

`ifdef REGFILE_WB_FWD_EN
        rd_num_1  = 5'd0;
        rd_num_2  = 5'd0;
        rd_data_1 = 32'h0;
        rd_data_2 = 32'h0;
`endif
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;

        // Table: inputs applied for one cycle, checked before the next edge.
        for (int i = 0; i < int'(NVEC); i++) begin
            drive(vecs[i].rst, vecs[i].av, vecs[i].an, vecs[i].ad,
                  vecs[i].mv, vecs[i].mn, vecs[i].md);
            @(negedge clk);
            check($sformatf("v%0d alu_ready", i), 32'(bus0.alu_ready), 32'(vecs[i].ear));
            check($sformatf("v%0d mem_ready", i), 32'(bus0.mem_ready), 32'(vecs[i].emr));
            check($sformatf("v%0d writeReg", i), 32'(bus0.writeReg), 32'(vecs[i].ewe));
            check($sformatf("v%0d write_reg_num", i), 32'(bus0.write_reg_num), 32'(vecs[i].enum_r));
            check($sformatf("v%0d write_data", i), bus0.write_data, vecs[i].edata);
            check($sformatf("v%0d conflict_cnt", i), 32'(cnt0), 32'(vecs[i].ecnt));
            if (vecs[i].r0chk) begin
                check("r0 nodrop writeReg", 32'(bus1.writeReg), 32'd1);
                check("r0 nodrop write_reg_num", 32'(bus1.write_reg_num), 32'd0);
                check("r0 nodrop write_data", bus1.write_data, 32'h55);
            end
            @(posedge clk);
            #1;
        end

        // Sustained contention: alternating grants, writes every cycle, counter saturates.
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
            @(negedge clk);
            check($sformatf("sat%0d alu_ready", i), 32'(bus0.alu_ready), 32'((i % 2) == 0));
            check($sformatf("sat%0d mem_ready", i), 32'(bus0.mem_ready), 32'((i % 2) == 1));
            check($sformatf("sat%0d cnt", i), 32'(cnt0), (4 + i > 15) ? 32'd15 : 32'(4 + i));
            if (i > 0) begin
                check($sformatf("sat%0d writeReg", i), 32'(bus0.writeReg), 32'd1);
                check($sformatf("sat%0d write_reg_num", i), 32'(bus0.write_reg_num),
                      ((i - 1) % 2 == 0) ? 32'd1 : 32'd2);
            end
            @(posedge clk);
            #1;
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("sat end cnt", 32'(cnt0), 32'd15);
        check("sat end cnt wide", 32'(cnt1), 32'd24);
        check("sat end writeReg", 32'(bus0.writeReg), 32'd1);
        check("sat end write_reg_num", 32'(bus0.write_reg_num), 32'd2);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post sat cnt hold", 32'(cnt0), 32'd15);
        check("post sat writeReg", 32'(bus0.writeReg), 32'd0);
        @(posedge clk);
        #1;

`ifdef REGFILE_WB_FWD_EN
        // Forward the committing write to a matching read port; r0 never forwards.
        drive(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rd_num_1  = 5'd7;
        rd_data_1 = 32'h1;
        rd_num_2  = 5'd0;
        rd_data_2 = 32'h1234;
        @(negedge clk);
        check("fwd_data_1 hit", fwd0_1, 32'hA5A5A5A5);
        check("fwd_data_2 r0", fwd0_2, 32'h1234);
        rd_num_1 = 5'd6;
        #1;
        check("fwd_data_1 miss", fwd0_1, 32'h1);
        @(posedge clk);
        #1;
        rd_num_1 = 5'd7;
        #1;
        check("fwd_data_1 no write", fwd0_1, 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two writeback requesters: ALU (requester 0) and memory/load (requester 1).
- Valid/ready handshake per requester, round-robin arbitration and a registered output stage that drives the register file write port directly.
- Counts contention cycles for performance debug.
- Sits between the execute/memory stages and the register file.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register number.
- CNT_W, 16, width of saturating contention counter.
- DROP_R0, 1, when 1, writes to register 0 are accepted but never issued to the register file.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- alu_valid  input  1  ALU writeback request.
- alu_ready  output  1  ALU request accepted this cycle.
- alu_num  input  ADDR_W  ALU destination register.
- alu_data  input  DATA_W  ALU result.
- mem_valid  input  1  load writeback request.
- mem_ready  output  1  load request accepted this cycle.
- mem_num  input  ADDR_W  load destination register.
- mem_data  input  DATA_W  load data.
- writeReg  output  1  register file write enable (registered).
- write_reg_num  output  ADDR_W  register file write address (registered).
- write_data  output  DATA_W  register file write data (registered).
- conflict_cnt  output  CNT_W  cycles in which both requesters were valid.

Behaviour:
- Handshake: transfer occurs when valid and ready are both high in the same cycle. Ready is combinational from valid and arbiter state, never from data. Ready is 0 while rst is high.
- The register file accepts one write per cycle, so the output stage drains every cycle and never backpressures.
- Grant rules:
  - Only one requester valid: it is granted.
  - Both valid: the requester not granted last wins.
  - Neither valid: no grant; last_grant is unchanged.
- last_grant (1 bit) updates to the granted index on every grant. Reset value is 1, so the ALU wins the first contention.
- Exactly one of alu_ready/mem_ready is high when any valid is high; both are low otherwise.
- Latency: a request accepted in cycle N appears on writeReg/write_reg_num/write_data in cycle N+1, for exactly one cycle.
- Idle cycle after a grant: writeReg=0; write_reg_num/write_data hold their last values.
- Register 0 handling: with DROP_R0=1, an accepted request with num==0 still sets ready=1 and updates last_grant, but writeReg stays 0 in N+1. With DROP_R0=0 it is issued normally.
- The losing requester must hold valid/num/data stable until accepted. The block does not latch unaccepted requests.
- conflict_cnt increments by 1 each cycle in which alu_valid and mem_valid are both high. It saturates at all-ones (no wrap).
- Reset values: writeReg=0, write_reg_num=0, write_data=0, conflict_cnt=0, last_grant=1.
- Reset mid-operation: a request accepted in the cycle rst is sampled high is discarded (writeReg=0 the next cycle). No handshake completes while rst=1.
- Back-to-back: with both valid continuously, grants alternate ALU, MEM, ALU, ... and writeReg stays high every cycle.

Optional Feature:
- Macro: REGFILE_WB_FWD_EN.
- When defined, adds these ports:
  - rd_num_1, rd_num_2: input ADDR_W.
  - rd_data_1, rd_data_2: input DATA_W, from the register file read ports.
  - fwd_data_1, fwd_data_2: output DATA_W.
- Forwarding rule: fwd_data_k = write_data when writeReg=1 and write_reg_num==rd_num_k and rd_num_k!=0; otherwise fwd_data_k = rd_data_k. Combinational; bypasses the write being committed this cycle.
- When the macro is undefined, these ports and that logic do not exist. All other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles with alu_valid=1 -> alu_ready=0, writeReg=0, conflict_cnt=0; first cycle after release, alu_ready=1.
- Single ALU write: alu_valid=1, alu_num=5, alu_data=0xDEADBEEF for one cycle -> next cycle writeReg=1, write_reg_num=5, write_data=0xDEADBEEF; the following cycle writeReg=0.
- Contention: both valid for 4 cycles (ALU num 1/data 0x11, MEM num 2/data 0x22, held until accepted) -> grants in order ALU, MEM, ALU, MEM; conflict_cnt=4; writeReg high 4 consecutive cycles.
- R0 drop: mem_valid=1, mem_num=0, mem_data=0x55 with DROP_R0=1 -> mem_ready=1, next cycle writeReg=0. With DROP_R0=0 -> writeReg=1, write_reg_num=0.
- Saturation: CNT_W=4, both valid for 20 cycles -> conflict_cnt stops at 15.
- Forwarding (REGFILE_WB_FWD_EN): commit num 7/data 0xA5A5A5A5, with rd_num_1=7 and rd_data_1=0x1 in the commit cycle -> fwd_data_1=0xA5A5A5A5. With rd_num_2=0 -> fwd_data_2=rd_data_2.
